left_rotator: RTL and testbench
===============================

Name: left_rotator

Overview:
- Registered left barrel rotator. Rotates a WIDTH-bit word left by a runtime amount from 0 to WIDTH-1.
- Bits shifted out of the MSB re-enter at the LSB; no bits are lost.
- Core of the multi-barrel rotator datapath. Sits between the operand source and the downstream rotate consumers.
- The combinational network is logarithmic (one mux stage per amount bit), followed by an output register.

Parameters:
- WIDTH, 8, data width in bits; must be a power of 2, minimum 2.
- SHIFT_W, $clog2(WIDTH) (3 by default), width of the rotate amount; derived, never overridden independently.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies d_in and bit_amount this cycle.
- d_in  input  WIDTH  word to rotate.
- bit_amount  input  SHIFT_W  left-rotate amount, unsigned, range 0..WIDTH-1.
- out_valid  output  1  d_out holds a result for a qualified input.
- d_out  output  WIDTH  rotated word.

Behaviour:
- Function: d_out = (d_in << bit_amount) | (d_in >> (WIDTH - bit_amount)), truncated to WIDTH bits.
  - Equivalently, d_out[i] = d_in[(i - bit_amount) mod WIDTH].
- bit_amount = 0: d_out = d_in (pass-through). No special-case path; handled by the stage muxes.
- Barrel structure: stage k (k = 0..SHIFT_W-1) rotates left by 2^k when bit_amount[k] = 1, otherwise passes through. Stages are applied in ascending k.
- Latency: 1 clock.
  - On a rising clk with in_valid = 1: d_out <= rotated value, out_valid <= 1.
  - On a rising clk with in_valid = 0: d_out holds its previous value, out_valid <= 0.
- Throughput: one result per clock. There is no backpressure and no ready signal; the consumer must accept every out_valid pulse.
- Reset: while rst_n = 0, out_valid = 0 and d_out = 0 immediately, independent of clk.
  - Deassertion is synchronised externally.
  - The first rising clk after release with in_valid = 1 produces valid output.
- Reset mid-stream: any in-flight result is discarded. No out_valid is emitted for inputs captured before or during reset.
- Inputs with in_valid = 0 are don't-care; X on them must not propagate to d_out.
- No internal state other than the output register (plus the pipeline register when the optional feature is enabled).

Optional Feature:
- Macro: LEFT_ROTATOR_PIPE_EN.
- Defined:
  - An extra register stage is inserted after stage SHIFT_W/2 - 1 of the barrel network. For SHIFT_W = 1, the register sits before the single stage.
  - Latency becomes 2 clocks; throughput remains 1 per clock.
  - in_valid is pipelined alongside the data, so out_valid aligns with the matching d_out.
  - The pipeline register is cleared to 0, with its valid bit 0, by rst_n.
- Not defined: latency is 1 clock, with no intermediate register.
- Function, reset values and port list are identical in both builds.

Test Plan:
- Sweep, WIDTH = 8: d_in = 8'b10010010, in_valid = 1, bit_amount = 0..7 on consecutive clocks. Required d_out, one clock later in order:
  - 10010010, 00100101, 01001010, 10010100, 00101001, 01010010, 10100100, 01001001.
  - out_valid = 1 on each of those cycles.
- Edge patterns: d_in = 8'hFF and 8'h00 at every amount -> d_out unchanged. d_in = 8'h01 with amount 7 -> 8'h80. d_in = 8'h80 with amount 1 -> 8'h01.
- Valid gating: in_valid pulses 1,0,1 with d_in = 8'hA5, bit_amount = 1 -> out_valid pulses 1,0,1 one clock later; d_out = 8'h4B and holds through the gap.
- Async reset: assert rst_n = 0 between clock edges while out_valid = 1 -> out_valid = 0 and d_out = 0 immediately. After release, the next valid input produces its result after the normal latency.
- Random: 1000 random d_in / bit_amount pairs, compared against a reference model. Run with and without LEFT_ROTATOR_PIPE_EN, checking latency 1 vs 2.
- Parameter: WIDTH = 16, d_in = 16'h8001, bit_amount = 15 -> d_out = 16'hC000.

Source files
------------

// File: rtl/left_rotator.sv
// left_rotator: registered left barrel rotator.
// d_out = d_in rotated left by bit_amount (0..WIDTH-1), one mux stage per
// amount bit (stage k rotates by 2^k), followed by an output register.
// Build option: define LEFT_ROTATOR_PIPE_EN to insert a register after
// stage SHIFT_W/2-1 (before stage 0 when SHIFT_W = 1); latency becomes 2.
module left_rotator #(
  parameter  int WIDTH   = 8,
  localparam int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   d_in,
  input  logic [SHIFT_W-1:0] bit_amount,
  output logic               out_valid,
  output logic [WIDTH-1:0]   d_out
);

  // w_net[k] is the input of stage k; w_net[SHIFT_W] is the fully rotated word
  logic [WIDTH-1:0] w_net [0:SHIFT_W];
  logic             w_vld;
  logic [WIDTH-1:0] r_out;
  logic             r_vld;

  assign w_net[0] = d_in;

`ifdef LEFT_ROTATOR_PIPE_EN
  localparam int PIPE_AT = SHIFT_W / 2;

  logic [WIDTH-1:0]         r_pipe_d;
  logic [SHIFT_W-1:PIPE_AT] r_pipe_amt;   // only the bits the back stages use
  logic                     r_pipe_vld;

  // mid-network register; loads only on qualified input so X never enters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_d   <= '0;
      r_pipe_amt <= '0;
      r_pipe_vld <= 1'b0;
    end else begin
      r_pipe_vld <= in_valid;
      if (in_valid) begin
        r_pipe_d   <= w_net[PIPE_AT];
        r_pipe_amt <= bit_amount[SHIFT_W-1:PIPE_AT];
      end
    end
  end

  assign w_vld = r_pipe_vld;
`else
  assign w_vld = in_valid;
`endif

  for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
    localparam int S = 1 << k;
    logic [WIDTH-1:0] w_src;
    logic             w_sel;
`ifdef LEFT_ROTATOR_PIPE_EN
    if (k == PIPE_AT) begin : g_cut
      assign w_src = r_pipe_d;
    end else begin : g_thru
      assign w_src = w_net[k];
    end
    if (k >= PIPE_AT) begin : g_back
      assign w_sel = r_pipe_amt[k];
    end else begin : g_front
      assign w_sel = bit_amount[k];
    end
`else
    assign w_src = w_net[k];
    assign w_sel = bit_amount[k];
`endif
    assign w_net[k+1] = w_sel ? {w_src[WIDTH-1-S:0], w_src[WIDTH-1:WIDTH-S]} : w_src;
  end

  // output register: capture on valid, hold otherwise, clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= w_vld;
      if (w_vld) r_out <= w_net[SHIFT_W];
    end
  end

  assign d_out     = r_out;
  assign out_valid = r_vld;

endmodule

// File: tb/tb_left_rotator.sv
// Directed + random bench for left_rotator (8-bit instance, plus a 16-bit
// instance for the parameter check). Works with or without
// LEFT_ROTATOR_PIPE_EN; expected outputs are delayed by the build latency.
module tb_left_rotator;

`ifdef LEFT_ROTATOR_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  d_in;
  logic [2:0]  bit_amount;
  logic        out_valid;
  logic [7:0]  d_out;

  logic        in_valid16;
  logic [15:0] d_in16;
  logic [3:0]  bit_amount16;
  logic        out_valid16;
  logic [15:0] d_out16;

  int n_assert = 0;
  int n_fail   = 0;

  // expected-output model state
  logic       exp_v, p_v;
  logic [7:0] exp_d, p_d;

  always #5 clk = ~clk;

  left_rotator #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .d_in(d_in),
    .bit_amount(bit_amount), .out_valid(out_valid), .d_out(d_out)
  );

  left_rotator #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .d_in(d_in16),
    .bit_amount(bit_amount16), .out_valid(out_valid16), .d_out(d_out16)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, clock, then check against the delayed expectation
  task automatic step(input logic v, input logic [7:0] d, input logic [2:0] a,
                      input logic [7:0] e, input string tag);
    logic       nv;
    logic [7:0] nd;
    in_valid   = v;
    d_in       = v ? d : 8'hxx;
    bit_amount = v ? a : 3'bxxx;
    @(posedge clk); #1;
    if (LAT == 2) begin
      nv = p_v; nd = p_d; p_v = v; p_d = e;
    end else begin
      nv = v; nd = e;
    end
    exp_v = nv;
    if (nv) exp_d = nd;
    chk({tag, ".vld"}, {15'd0, out_valid}, {15'd0, exp_v});
    chk({tag, ".dat"}, {8'd0, d_out}, {8'd0, exp_d});
  endtask

  function automatic logic [7:0] rot_ref(input logic [7:0] d, input logic [2:0] a);
    logic [15:0] t;
    t = {d, d} << a;
    return t[15:8];
  endfunction

  initial begin
    logic [7:0] sweep [0:7];
    logic [7:0] rd;
    logic [2:0] ra;
    logic       rv;
    sweep = '{8'b10010010, 8'b00100101, 8'b01001010, 8'b10010100,
              8'b00101001, 8'b01010010, 8'b10100100, 8'b01001001};
    exp_v = 1'b0; exp_d = 8'h00; p_v = 1'b0; p_d = 8'h00;
    rst_n = 1'b0; in_valid = 1'b0; d_in = 8'h00; bit_amount = 3'd0;
    in_valid16 = 1'b0; d_in16 = 16'h0; bit_amount16 = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.vld", {15'd0, out_valid}, 16'h0);
    chk("reset.dat", {8'd0, d_out}, 16'h0);
    chk("reset16.vld", {15'd0, out_valid16}, 16'h0);
    chk("reset16.dat", d_out16, 16'h0);
    rst_n = 1'b1;

    // 16-bit instance: steady input, checked later
    in_valid16 = 1'b1; d_in16 = 16'h8001; bit_amount16 = 4'd15;

    // sweep of amounts on consecutive clocks
    for (int i = 0; i < 8; i++) step(1'b1, 8'b10010010, 3'(i), sweep[i], "sweep");
    for (int i = 0; i < LAT; i++) step(1'b0, 8'h00, 3'd0, 8'h00, "sweep_drain");

    chk("w16.vld", {15'd0, out_valid16}, 16'h1);
    chk("w16.dat", d_out16, 16'hC000);
    in_valid16 = 1'b0;

    // edge patterns
    for (int i = 0; i < 8; i++) step(1'b1, 8'hFF, 3'(i), 8'hFF, "ones");
    for (int i = 0; i < 8; i++) step(1'b1, 8'h00, 3'(i), 8'h00, "zeros");
    step(1'b1, 8'h01, 3'd7, 8'h80, "lsb_rot7");
    step(1'b1, 8'h80, 3'd1, 8'h01, "msb_wrap");

    // valid gating with hold through the gap (invalid inputs driven as X)
    step(1'b1, 8'hA5, 3'd1, 8'h4B, "gate1");
    step(1'b0, 8'hA5, 3'd1, 8'h00, "gate0");
    step(1'b1, 8'hA5, 3'd1, 8'h4B, "gate2");
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 8'h00, 3'd0, 8'h00, "gate_hold");

    // async reset mid-stream while out_valid is high
    step(1'b1, 8'h3C, 3'd2, 8'hF0, "pre_rst0");
    step(1'b1, 8'h3C, 3'd2, 8'hF0, "pre_rst1");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.vld", {15'd0, out_valid}, 16'h0);
    chk("async_rst.dat", {8'd0, d_out}, 16'h0);
    p_v = 1'b0; exp_d = 8'h00;
    in_valid = 1'b1; d_in = 8'h55; bit_amount = 3'd3;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step(1'b0, 8'h00, 3'd0, 8'h00, "post_rst_idle");
    step(1'b1, 8'h81, 3'd3, 8'h0C, "post_rst0");
    for (int i = 0; i < LAT; i++) step(1'b0, 8'h00, 3'd0, 8'h00, "post_rst_drain");

    // random pairs against the reference model
    for (int i = 0; i < 1000; i++) begin
      rd = 8'($urandom);
      ra = 3'($urandom_range(0, 7));
      rv = ($urandom_range(0, 7) != 0);
      step(rv, rd, ra, rot_ref(rd, ra), "rand");
    end
    for (int i = 0; i < LAT; i++) step(1'b0, 8'h00, 3'd0, 8'h00, "rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
